// File: rtl/arrow_sequencer_if.sv
// rtl/arrow_sequencer_if.sv - generator and playfield handshake bundle for arrow_sequencer
interface arrow_sequencer_if #(
    parameter int NUM_ARROWS_BITS = 1
);
    // Generator side: the seed rides alongside rand_load so the generator sees both together
    logic [5:0]               sw;
    logic [5:0]               rand_num;
    logic                     rand_load;
    logic                     rand_step;
    // Playfield side: head of the step FIFO and its pop handshake
    logic                     head_valid;
    logic [NUM_ARROWS_BITS:0] head_arrow;
    logic                     head_rest;
    logic                     pop;

    modport master (
        output rand_load, rand_step, head_valid, head_arrow, head_rest,
        input  rand_num, pop
    );

    modport slave (
        input  sw, rand_load, rand_step, head_valid, head_arrow, head_rest,
        output rand_num, pop
    );
endinterface

// File: rtl/arrow_sequencer.sv
// rtl/arrow_sequencer.sv - beat-driven arrow generator sequencer with step FIFO
module arrow_sequencer #(
    parameter int NUM_ARROWS      = 4,
    parameter int NUM_ARROWS_BITS = 1,
    parameter int DEPTH           = 4,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    arrow_sequencer_if.master bus,
    output logic [CNT_W-1:0]  spawn_count,
    output logic              overflow,
    output logic              busy
);
    localparam int AW   = $clog2(DEPTH);
    localparam int AR_W = NUM_ARROWS_BITS + 1;
    localparam int EW   = AR_W + 1;
    localparam logic [5:0]       LANES   = 6'(NUM_ARROWS);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, SEED, RUN, PAUSED} state_t;

    state_t             state, state_nx;
    logic               start_q;
    logic               step_q;
    logic               sample_q;
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [EW-1:0]      mem [DEPTH];
    logic [EW-1:0]      head_entry;
    logic               empty, full;
    logic               do_push, do_pop, drop;
    logic               entry_rest;
    logic [AR_W-1:0]    entry_arrow;
    logic               beat_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Pause gates beats immediately, even in the cycle before PAUSED is entered
    assign beat_ok = beat && (state == RUN) && !pause && !stop;

    // stop wins over everything, including a pop or push landing in the same cycle
    assign do_pop  = bus.pop && !empty && !stop;
    assign do_push = sample_q && !stop && (!full || do_pop);
    assign drop    = sample_q && !stop && full && !do_pop;

    // Rests carry lane 0 so a rest head never shows a stale lane
    assign entry_rest  = (bus.rand_num[5:4] == 2'b00);
    assign entry_arrow = entry_rest ? '0 : AR_W'(bus.rand_num % LANES);

    assign head_entry     = mem[rd_ptr[AW-1:0]];
    assign bus.head_valid = !empty;
    assign bus.head_arrow = empty ? '0 : head_entry[AR_W-1:0];
    assign bus.head_rest  = !empty && head_entry[AR_W];
    assign bus.rand_load  = (state == SEED);
    assign bus.rand_step  = step_q;
    assign busy           = (state != IDLE);

    // State register and previous-cycle start for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start;
        end
    end

    // Next-state logic, stop has priority from any state
    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !start_q) state_nx = SEED;
                SEED:    state_nx = RUN;
                RUN:     if (pause) state_nx = PAUSED;
                PAUSED:  if (!pause) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Two-stage step pipeline: pulse rand_step, then sample the advanced generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= 1'b0;
            sample_q <= 1'b0;
        end else if (stop) begin
            step_q   <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            step_q   <= beat_ok;
            sample_q <= step_q;
        end
    end

    // FIFO pointers, spawn counter and sticky overflow; stop flushes all of them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            spawn_count <= '0;
            overflow    <= 1'b0;
        end else if (stop) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            spawn_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr      <= wr_ptr + PTR_ONE;
                spawn_count <= spawn_count + CNT_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (drop)   overflow <= 1'b1;
        end
    end

    // FIFO storage; on full-with-pop the write slot is the one being vacated
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {entry_rest, entry_arrow};
    end
endmodule
